// File: rtl/wam_inp.sv
// Input conditioner for the whac-a-mole board: 2-flop sync, tick-based debounce and edge strobes.
// Define WAM_INP_REPEAT_EN to enable auto-repeat on the lft/rgt buttons.
module wam_inp #(
  parameter int unsigned N_BTN    = 3,
  parameter int unsigned N_SW     = 8,
  parameter int unsigned TICK_W   = 16,
  parameter int unsigned DB_TICKS = 4,
  parameter int unsigned REP_DLY  = 32,
  parameter int unsigned REP_PER  = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_SW-1:0]  sw_raw,
  output logic [N_BTN-1:0] btn_lvl,
  output logic [N_BTN-1:0] btn_pls,
  output logic [N_SW-1:0]  sw_lvl,
  output logic [N_SW-1:0]  sw_rise,
  output logic [N_SW-1:0]  sw_fall
);

  localparam int unsigned NCh  = N_BTN + N_SW;
  localparam int unsigned DbW  = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
  localparam logic [DbW-1:0] DbLast = DbW'(DB_TICKS - 1);

  typedef enum logic [1:0] {SLo, SUp, SHi, SDn} ch_st_e;

  if (DB_TICKS < 1 || REP_DLY < 1 || REP_PER < 1) begin : g_bad_param
    $error("wam_inp: DB_TICKS, REP_DLY and REP_PER must all be >= 1");
  end

  // Buttons occupy the low channel indices, switches sit above them.
  logic [NCh-1:0] raw;
  logic [NCh-1:0] sync1_q;
  logic [NCh-1:0] s_q;

  assign raw = {sw_raw, btn_raw};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1_q <= '0;
      s_q     <= '0;
    end else begin
      sync1_q <= raw;
      s_q     <= sync1_q;
    end
  end

  logic [TICK_W-1:0] tick_q;
  logic              tick;

  assign tick = &tick_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_q + TICK_W'(1);
    end
  end

`ifdef WAM_INP_REPEAT_EN
  localparam int unsigned RepN = (N_BTN < 2) ? N_BTN : 2;
  logic [RepN-1:0] hold;
`endif

  // evt is a one-clk strobe on every accepted change; its direction is read from lvl.
  logic [NCh-1:0] lvl;
  logic [NCh-1:0] evt;

  for (genvar i = 0; i < NCh; i++) begin : g_ch
    ch_st_e         st_q;
    logic [DbW-1:0] cnt_q;
    logic           lvl_q;
    logic           evt_q;

    always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
        st_q  <= SLo;
        cnt_q <= '0;
        lvl_q <= 1'b0;
        evt_q <= 1'b0;
      end else begin
        evt_q <= 1'b0;
        unique case (st_q)
          SLo: begin
            if (s_q[i]) begin
              st_q  <= SUp;
              cnt_q <= '0;
            end
          end
          SUp: begin
            if (!s_q[i]) begin
              st_q <= SLo;
            end else if (tick) begin
              if (cnt_q == DbLast) begin
                st_q  <= SHi;
                lvl_q <= 1'b1;
                evt_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + DbW'(1);
              end
            end
          end
          SHi: begin
            if (!s_q[i]) begin
              st_q  <= SDn;
              cnt_q <= '0;
            end
          end
          SDn: begin
            if (s_q[i]) begin
              st_q <= SHi;
            end else if (tick) begin
              if (cnt_q == DbLast) begin
                st_q  <= SLo;
                lvl_q <= 1'b0;
                evt_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + DbW'(1);
              end
            end
          end
          default: begin
            st_q  <= SLo;
            cnt_q <= '0;
            lvl_q <= 1'b0;
          end
        endcase
      end
    end

    assign lvl[i] = lvl_q;
    assign evt[i] = evt_q;

`ifdef WAM_INP_REPEAT_EN
    if (i < RepN) begin : g_hold
      assign hold[i] = (st_q == SHi) && s_q[i];
    end
`endif
  end

  logic [N_BTN-1:0] btn_rise;

  assign btn_rise = evt[N_BTN-1:0] & lvl[N_BTN-1:0];
  assign btn_lvl  = lvl[N_BTN-1:0];
  assign sw_lvl   = lvl[NCh-1:N_BTN];
  assign sw_rise  = evt[NCh-1:N_BTN] & lvl[NCh-1:N_BTN];
  assign sw_fall  = evt[NCh-1:N_BTN] & ~lvl[NCh-1:N_BTN];

`ifdef WAM_INP_REPEAT_EN
  localparam int unsigned RepMax = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
  localparam int unsigned RepW   = (RepMax > 1) ? $clog2(RepMax) : 1;
  localparam logic [RepW-1:0] RepDlyLast = RepW'(REP_DLY - 1);
  localparam logic [RepW-1:0] RepPerLast = RepW'(REP_PER - 1);

  logic [N_BTN-1:0] rep_pls;

  for (genvar b = 0; b < N_BTN; b++) begin : g_rep
    if (b < RepN) begin : g_on
      logic [RepW-1:0] rep_cnt_q;
      logic            rep_first_q;
      logic            rep_q;

      // Counts ticks only while steadily held in SHi; any excursion restarts the initial delay.
      always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
          rep_cnt_q   <= '0;
          rep_first_q <= 1'b1;
          rep_q       <= 1'b0;
        end else begin
          rep_q <= 1'b0;
          if (!hold[b]) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
          end else if (tick) begin
            if (rep_cnt_q == (rep_first_q ? RepDlyLast : RepPerLast)) begin
              rep_q       <= 1'b1;
              rep_cnt_q   <= '0;
              rep_first_q <= 1'b0;
            end else begin
              rep_cnt_q <= rep_cnt_q + RepW'(1);
            end
          end
        end
      end

      assign rep_pls[b] = rep_q;
    end else begin : g_off
      assign rep_pls[b] = 1'b0;
    end
  end

  assign btn_pls = btn_rise | rep_pls;
`else
  assign btn_pls = btn_rise;
`endif

endmodule

// File: tb/tb_wam_inp.sv
// Directed bench for wam_inp: vector table for levels/strobes plus sequences for reset, glitch,
// latency window and auto-repeat (expectations follow WAM_INP_REPEAT_EN).
module tb_wam_inp;

  logic       clk = 1'b0;
  logic       clr;
  logic [2:0] btn_raw;
  logic [7:0] sw_raw;
  logic [2:0] btn_lvl;
  logic [2:0] btn_pls;
  logic [7:0] sw_lvl;
  logic [7:0] sw_rise;
  logic [7:0] sw_fall;

  wam_inp #(
    .N_BTN   (3),
    .N_SW    (8),
    .TICK_W  (2),
    .DB_TICKS(4),
    .REP_DLY (6),
    .REP_PER (3)
  ) dut (
    .clk    (clk),
    .clr    (clr),
    .btn_raw(btn_raw),
    .sw_raw (sw_raw),
    .btn_lvl(btn_lvl),
    .btn_pls(btn_pls),
    .sw_lvl (sw_lvl),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor accumulators, cleared per test section.
  logic [2:0] pls_or;
  logic [7:0] rise_or, fall_or, swlvl_or;
  int         pls_clks, rise_clks, fall_clks, edge_n;
  int         pls_at[$];

  task automatic mon_clear();
    pls_or = '0; rise_or = '0; fall_or = '0; swlvl_or = '0;
    pls_clks = 0; rise_clks = 0; fall_clks = 0; edge_n = 0;
    pls_at.delete();
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      edge_n++;
      if (|btn_pls) begin
        pls_clks++;
        pls_or |= btn_pls;
        pls_at.push_back(edge_n);
      end
      if (|sw_rise) rise_clks++;
      if (|sw_fall) fall_clks++;
      rise_or  |= sw_rise;
      fall_or  |= sw_fall;
      swlvl_or |= sw_lvl;
    end
  endtask

  typedef struct {
    logic [2:0] btn;
    logic [7:0] sw;
    logic [2:0] lvl_b;
    logic [7:0] lvl_s;
    logic [2:0] pls;
    logic [7:0] rise;
    logic [7:0] fall;
  } vec_t;

  vec_t vt[8];

  initial begin
    int first, exp_n;

    vt[0] = '{3'b000, 8'h00, 3'b000, 8'h00, 3'b000, 8'h00, 8'h00};
    vt[1] = '{3'b000, 8'hA5, 3'b000, 8'hA5, 3'b000, 8'hA5, 8'h00};
    vt[2] = '{3'b000, 8'h00, 3'b000, 8'h00, 3'b000, 8'h00, 8'hA5};
    vt[3] = '{3'b100, 8'h0F, 3'b100, 8'h0F, 3'b100, 8'h0F, 8'h00};
    vt[4] = '{3'b000, 8'hF0, 3'b000, 8'hF0, 3'b000, 8'hF0, 8'h0F};
    vt[5] = '{3'b100, 8'hFF, 3'b100, 8'hFF, 3'b100, 8'h0F, 8'h00};
    vt[6] = '{3'b000, 8'h3C, 3'b000, 8'h3C, 3'b000, 8'h00, 8'hC3};
    vt[7] = '{3'b000, 8'h00, 3'b000, 8'h00, 3'b000, 8'h00, 8'h3C};

    clr = 1'b1;
    btn_raw = '0;
    sw_raw = '0;
    mon_clear();
    run(3);
    chk("reset_outputs", {btn_lvl, btn_pls, sw_lvl, sw_rise, sw_fall}, 32'h0);
    clr = 1'b0;

    // Table: each vector held long enough for the slowest tick phase to accept.
    for (int v = 0; v < 8; v++) begin
      btn_raw = vt[v].btn;
      sw_raw  = vt[v].sw;
      mon_clear();
      run(22);
      chk($sformatf("v%0d_btn_lvl", v), btn_lvl, vt[v].lvl_b);
      chk($sformatf("v%0d_sw_lvl", v), sw_lvl, vt[v].lvl_s);
      chk($sformatf("v%0d_pls", v), pls_or, vt[v].pls);
      chk($sformatf("v%0d_rise", v), rise_or, vt[v].rise);
      chk($sformatf("v%0d_fall", v), fall_or, vt[v].fall);
      chk($sformatf("v%0d_pls_clks", v), pls_clks, (vt[v].pls != 0) ? 1 : 0);
      chk($sformatf("v%0d_rise_clks", v), rise_clks, (vt[v].rise != 0) ? 1 : 0);
      chk($sformatf("v%0d_fall_clks", v), fall_clks, (vt[v].fall != 0) ? 1 : 0);
    end

    // Async clear mid-run.
    sw_raw = 8'hFF;
    run(22);
    chk("pre_clr_sw_lvl", sw_lvl, 8'hFF);
    @(negedge clk);
    clr = 1'b1;
    #1;
    chk("async_clr_outputs", {btn_lvl, btn_pls, sw_lvl, sw_rise, sw_fall}, 32'h0);
    sw_raw = 8'h00;
    @(negedge clk);
    clr = 1'b0;
    mon_clear();
    run(30);
    chk("post_clr_idle", {pls_or, rise_or, fall_or, swlvl_or}, 32'h0);

    // Short glitch never accepted.
    mon_clear();
    sw_raw[3] = 1'b1;
    run(3);
    sw_raw[3] = 1'b0;
    run(30);
    chk("glitch_sw_lvl", swlvl_or, 8'h00);
    chk("glitch_rise_fall", {rise_or, fall_or}, 16'h0);

    // Hold lft about 40 ticks past acceptance.
    mon_clear();
    btn_raw = 3'b001;
    run(180);
    first = (pls_at.size() > 0) ? pls_at[0] : -1;
    chk("lft_latency_window", (first >= 15 && first <= 19) ? 1 : 0, 1);
    chk("lft_lvl", btn_lvl, 3'b001);
    chk("lft_pls_bits", pls_or, 3'b001);
`ifdef WAM_INP_REPEAT_EN
    exp_n = (first + 24 <= 180) ? 2 + (180 - (first + 24)) / 12 : 1;
`else
    exp_n = 1;
`endif
    chk("lft_pls_count", pls_at.size(), exp_n);
    for (int j = 1; j < exp_n && j < pls_at.size(); j++) begin
      chk($sformatf("lft_rep%0d_at", j), pls_at[j], first + 24 + (j - 1) * 12);
    end
    mon_clear();
    btn_raw = 3'b000;
    run(30);
    chk("lft_release_lvl", btn_lvl, 3'b000);
    chk("lft_release_no_pls", pls_clks, 0);

    // pse never repeats.
    mon_clear();
    btn_raw = 3'b100;
    run(180);
    chk("pse_pls_count", pls_at.size(), 1);
    chk("pse_pls_bits", pls_or, 3'b100);
    btn_raw = 3'b000;
    run(30);

    // clr during SUp, button still held afterwards.
    mon_clear();
    btn_raw = 3'b010;
    run(8);
    chk("rgt_no_early_pls", pls_clks, 0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    chk("rgt_clr_lvl", btn_lvl, 3'b000);
    clr = 1'b0;
    mon_clear();
    run(36);
    chk("rgt_pls_count", pls_clks, 1);
    chk("rgt_pls_bits", pls_or, 3'b010);
    chk("rgt_lvl", btn_lvl, 3'b010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
